// File: rtl/pipelined_cla_addsub_if.sv
// Operand/result bundle for the pipelined CLA adder/subtractor.
// Latency: none; this file only carries signals between producer and consumer.
// Backpressure: in_ready/out_ready carry the global stall in both directions.
interface pipelined_cla_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    // Producer side: issues operands and consumes results.
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    // Arithmetic block side.
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one WIDTH/STAGES-bit slice per stage, status flags at the end.
// Latency: STAGES cycles from accept to out_valid; one operation per cycle when not stalled.
// Backpressure: global stall, in_ready = ~out_valid | out_ready; every stage holds when it is low.
module pipelined_cla_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int GROUP  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipelined_cla_addsub_if.slave  bus
);
    localparam int SW = WIDTH / STAGES;
    localparam int NG = SW / GROUP;

    if ((WIDTH % STAGES) != 0) begin : g_chk_stages
        $error("pipelined_cla_addsub: WIDTH must be a multiple of STAGES");
    end
    if ((SW % GROUP) != 0) begin : g_chk_group
        $error("pipelined_cla_addsub: GROUP must divide WIDTH/STAGES");
    end

    // Two-level lookahead slice adder: group G/P, then group carries, then bit carries.
    // Returns {carry_out, sum}.
    function automatic logic [SW:0] cla_add(input logic [SW-1:0] x,
                                            input logic [SW-1:0] y,
                                            input logic          ci);
        logic [SW-1:0] g;
        logic [SW-1:0] p;
        logic [SW-1:0] c;
        logic [NG-1:0] gg;
        logic [NG-1:0] gp;
        logic [NG:0]   gc;
        logic          t;
        logic          pr;
        g  = x & y;
        p  = x ^ y;
        c  = '0;
        gg = '0;
        gp = '0;
        gc = '0;
        for (int j = 0; j < NG; j++) begin
            t  = 1'b0;
            pr = 1'b1;
            for (int i = GROUP - 1; i >= 0; i--) begin
                t  = t | (pr & g[j*GROUP + i]);
                pr = pr & p[j*GROUP + i];
            end
            gg[j] = t;
            gp[j] = pr;
        end
        gc[0] = ci;
        for (int j = 1; j <= NG; j++) begin
            t  = 1'b0;
            pr = 1'b1;
            for (int m = j - 1; m >= 0; m--) begin
                t  = t | (pr & gg[m]);
                pr = pr & gp[m];
            end
            gc[j] = t | (pr & ci);
        end
        for (int j = 0; j < NG; j++) begin
            for (int i = 0; i < GROUP; i++) begin
                t  = 1'b0;
                pr = 1'b1;
                for (int m = i - 1; m >= 0; m--) begin
                    t  = t | (pr & g[j*GROUP + m]);
                    pr = pr & p[j*GROUP + m];
                end
                c[j*GROUP + i] = t | (pr & gc[j]);
            end
        end
        return {gc[NG], p ^ c};
    endfunction

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic             ovf_q;
    logic             zero_q;

    // Subtraction is a + ~b + ~cin, so a borrow-in becomes an inverted carry-in.
    assign b_eff   = bus.sub ? ~bus.b : bus.b;
    assign c0      = bus.sub ? ~bus.cin : bus.cin;
    assign advance = ~g_stage[STAGES-1].v_q | bus.out_ready;

    // Each stage consumes the low slice of a rotating accumulator: operand A slices
    // shift down while finished sum slices enter at the top, so after the last
    // stage the accumulator holds the full sum in bit order. B only keeps the
    // slices still to be added, so its register shrinks stage by stage.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int REM = WIDTH - k*SW;

        logic [WIDTH-1:0] acc_in;
        logic [REM-1:0]   b_in;
        logic             c_in;
        logic             v_in;
        logic [SW:0]      slice_res;
        logic [WIDTH-1:0] acc_d;
        logic             c_d;
        logic [WIDTH-1:0] acc_q;
        logic             c_q;
        logic             v_q;

        if (k == 0) begin : g_src
            assign acc_in = bus.a;
            assign b_in   = b_eff;
            assign c_in   = c0;
            assign v_in   = bus.in_valid;
        end else begin : g_src
            assign acc_in = g_stage[k-1].acc_q;
            assign b_in   = g_stage[k-1].g_fwd.b_q;
            assign c_in   = g_stage[k-1].c_q;
            assign v_in   = g_stage[k-1].v_q;
        end

        assign slice_res = cla_add(acc_in[SW-1:0], b_in[SW-1:0], c_in);
        assign c_d       = slice_res[SW];

        if (SW == WIDTH) begin : g_one
            assign acc_d = slice_res[SW-1:0];
        end else begin : g_rot
            assign acc_d = {slice_res[SW-1:0], acc_in[WIDTH-1:SW]};
        end

        // Stage occupancy: bubbles travel as invalid entries, everything holds on stall.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q <= 1'b0;
            end else if (advance) begin
                v_q <= v_in;
            end
        end

        // Partial sum and slice carry, captured only for valid entries so the
        // final stage keeps its last result while out_valid is low.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                acc_q <= '0;
                c_q   <= 1'b0;
            end else if (advance && v_in) begin
                acc_q <= acc_d;
                c_q   <= c_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [REM-SW-1:0] b_q;

            // Remaining B slices for the later stages.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    b_q <= '0;
                end else if (advance && v_in) begin
                    b_q <= b_in[REM-1:SW];
                end
            end
        end else begin : g_flags
            logic ovf_d;
            logic zero_d;

            // The last slice still holds the operand sign bits in its top position.
            assign ovf_d  = (acc_in[SW-1] == b_in[SW-1]) && (slice_res[SW-1] != acc_in[SW-1]);
            assign zero_d = ~|acc_d;

            // Status flags registered alongside the final sum.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (advance && v_in) begin
                    ovf_q  <= ovf_d;
                    zero_q <= zero_d;
                end
            end
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = g_stage[STAGES-1].v_q;
    assign bus.sum       = g_stage[STAGES-1].acc_q;
    assign bus.cout      = g_stage[STAGES-1].c_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: 32/4, 64/8 and 16/1 configurations with a scoreboard each.
// Latency: expected results carry their accept edge; unstalled results must emerge after STAGES edges.
// Backpressure: out_ready is dropped in windows; in_ready and held outputs are checked there.
module tb_pipelined_cla_addsub;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] sum;
        logic        co;
        logic        of;
        logic        z;
        int          edge_n;
    } exp_t;

    pipelined_cla_addsub_if #(.WIDTH(32)) if0 ();
    pipelined_cla_addsub_if #(.WIDTH(64)) if1 ();
    pipelined_cla_addsub_if #(.WIDTH(16)) if2 ();

    pipelined_cla_addsub #(.WIDTH(32), .STAGES(4), .GROUP(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    pipelined_cla_addsub #(.WIDTH(64), .STAGES(8), .GROUP(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    pipelined_cla_addsub #(.WIDTH(16), .STAGES(1), .GROUP(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    logic        d_vld [3];
    logic [63:0] d_a   [3];
    logic [63:0] d_b   [3];
    logic        d_cin [3];
    logic        d_sub [3];
    logic        ordy;

    logic        o_ird [3];
    logic        o_ov  [3];
    logic [63:0] o_sum [3];
    logic        o_co  [3];
    logic        o_of  [3];
    logic        o_z   [3];

    assign if0.in_valid = d_vld[0]; assign if0.a = d_a[0][31:0]; assign if0.b = d_b[0][31:0];
    assign if0.cin = d_cin[0]; assign if0.sub = d_sub[0]; assign if0.out_ready = ordy;
    assign if1.in_valid = d_vld[1]; assign if1.a = d_a[1]; assign if1.b = d_b[1];
    assign if1.cin = d_cin[1]; assign if1.sub = d_sub[1]; assign if1.out_ready = ordy;
    assign if2.in_valid = d_vld[2]; assign if2.a = d_a[2][15:0]; assign if2.b = d_b[2][15:0];
    assign if2.cin = d_cin[2]; assign if2.sub = d_sub[2]; assign if2.out_ready = ordy;

    assign o_ird[0] = if0.in_ready; assign o_ov[0] = if0.out_valid; assign o_sum[0] = {32'd0, if0.sum};
    assign o_co[0] = if0.cout; assign o_of[0] = if0.ovf; assign o_z[0] = if0.zero;
    assign o_ird[1] = if1.in_ready; assign o_ov[1] = if1.out_valid; assign o_sum[1] = if1.sum;
    assign o_co[1] = if1.cout; assign o_of[1] = if1.ovf; assign o_z[1] = if1.zero;
    assign o_ird[2] = if2.in_ready; assign o_ov[2] = if2.out_valid; assign o_sum[2] = {48'd0, if2.sum};
    assign o_co[2] = if2.cout; assign o_of[2] = if2.ovf; assign o_z[2] = if2.zero;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_stall [3];
    logic acc_seen [3];
    logic p_ov  [3];
    logic [63:0] p_sum [3];
    logic p_co  [3];
    logic p_of  [3];
    logic p_z   [3];
    logic p_ordy;
    logic p_rst;

    function automatic int wid(int id);
        return (id == 0) ? 32 : ((id == 1) ? 64 : 16);
    endfunction

    function automatic int stg(int id);
        return (id == 0) ? 4 : ((id == 1) ? 8 : 1);
    endfunction

    // Reference: plain wide addition of a, the effective b and the effective carry.
    function automatic exp_t model(int w, logic [63:0] a, logic [63:0] b, logic cin, logic sub);
        logic [64:0] t;
        logic [63:0] mask;
        logic [63:0] am;
        logic [63:0] be;
        exp_t e;
        mask     = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        am       = a & mask;
        be       = (sub ? ~b : b) & mask;
        t        = {1'b0, am} + {1'b0, be} + {64'd0, (sub ? ~cin : cin)};
        e.sum    = t[63:0] & mask;
        e.co     = t[w];
        e.of     = (am[w-1] == be[w-1]) && (e.sum[w-1] != am[w-1]);
        e.z      = (e.sum == 64'd0);
        e.edge_n = 0;
        return e;
    endfunction

    function automatic int qsize(int id);
        case (id)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push_exp(int id, exp_t e);
        case (id)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(int id, output exp_t e);
        case (id)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    task automatic clear_q(int id);
        case (id)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Observe one DUT between edges: record accepts, compare emitted results, check stalls.
    task automatic sample(int id);
        exp_t e;
        acc_seen[id] = 1'b0;
        if (!rst_n) begin
            clear_q(id);
        end else begin
            if (d_vld[id] && o_ird[id]) begin
                e        = model(wid(id), d_a[id], d_b[id], d_cin[id], d_sub[id]);
                e.edge_n = cyc + 1;
                push_exp(id, e);
                acc_seen[id] = 1'b1;
            end
            if (o_ov[id] && !ordy) begin
                last_stall[id] = cyc;
                chk($sformatf("in_ready_stall%0d", id), o_ird[id], 0);
            end
            if (p_rst && p_ov[id] && !p_ordy) begin
                chk($sformatf("hold_valid%0d", id), o_ov[id], p_ov[id]);
                chk($sformatf("hold_sum%0d", id), o_sum[id], p_sum[id]);
                chk($sformatf("hold_flags%0d", id), {o_co[id], o_of[id], o_z[id]}, {p_co[id], p_of[id], p_z[id]});
            end
            if (o_ov[id] && ordy) begin
                checks++;
                assert (qsize(id) > 0) else begin
                    errors++;
                    $error("FAIL unexpected_out%0d observed=out_valid sum=0x%0h expected=no result", id, o_sum[id]);
                end
                if (qsize(id) > 0) begin
                    pop_exp(id, e);
                    chk($sformatf("sum%0d", id), o_sum[id], e.sum);
                    chk($sformatf("cout%0d", id), o_co[id], e.co);
                    chk($sformatf("ovf%0d", id), o_of[id], e.of);
                    chk($sformatf("zero%0d", id), o_z[id], e.z);
                    if (last_stall[id] < e.edge_n)
                        chk($sformatf("latency%0d", id), cyc, e.edge_n + stg(id) - 1);
                end
            end
        end
        p_ov[id]  = o_ov[id];
        p_sum[id] = o_sum[id];
        p_co[id]  = o_co[id];
        p_of[id]  = o_of[id];
        p_z[id]   = o_z[id];
    endtask

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 3; i++) sample(i);
        p_ordy = ordy;
        p_rst  = rst_n;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic issue(int id, logic [63:0] a, logic [63:0] b, logic cin, logic sub);
        int n;
        n = 0;
        d_a[id] = a; d_b[id] = b; d_cin[id] = cin; d_sub[id] = sub; d_vld[id] = 1'b1;
        do begin
            tick();
            n++;
        end while (!acc_seen[id] && n < 50);
        chk($sformatf("accept%0d", id), acc_seen[id], 1);
        d_vld[id] = 1'b0;
    endtask

    task automatic drain(int id);
        int n;
        n = 0;
        while (qsize(id) > 0 && n < 200) begin
            tick();
            n++;
        end
        chk($sformatf("drain%0d", id), qsize(id), 0);
    endtask

    task automatic rand_op(int id);
        d_a[id]   = {$urandom(), $urandom()};
        d_b[id]   = {$urandom(), $urandom()};
        d_cin[id] = 1'($urandom_range(0, 1));
        d_sub[id] = 1'($urandom_range(0, 1));
    endtask

    // Continuous stream with in_valid held high; out_ready low for cycles lo..hi.
    task automatic run_stream(int id, int n, int lo, int hi);
        int t;
        int done;
        t = 0;
        done = 0;
        rand_op(id);
        d_vld[id] = 1'b1;
        while (done < n && t < 500) begin
            ordy = !(t >= lo && t <= hi);
            tick();
            t++;
            if (acc_seen[id]) begin
                done++;
                rand_op(id);
            end
        end
        d_vld[id] = 1'b0;
        ordy = 1'b1;
        chk($sformatf("stream_accepts%0d", id), done, n);
        drain(id);
    endtask

    initial begin
        rst_n = 1'b0;
        ordy  = 1'b1;
        p_ordy = 1'b1;
        p_rst  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d_vld[i] = 1'b0; d_a[i] = '0; d_b[i] = '0; d_cin[i] = 1'b0; d_sub[i] = 1'b0;
            last_stall[i] = -1; acc_seen[i] = 1'b0;
            p_ov[i] = 1'b0; p_sum[i] = '0; p_co[i] = 1'b0; p_of[i] = 1'b0; p_z[i] = 1'b0;
        end

        // Reset state
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_valid%0d", i), o_ov[i], 0);
            chk($sformatf("rst_sum%0d", i), o_sum[i], 0);
            chk($sformatf("rst_flags%0d", i), {o_co[i], o_of[i], o_z[i]}, 0);
        end
        rst_n = 1'b1;
        ordy  = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("rst_in_ready%0d", i), o_ird[i], 1);
        ordy = 1'b1;
        tick();

        // Single operation, then idle cycles so a duplicate output would be caught
        issue(0, 64'h0000_0005, 64'h0000_0003, 1'b0, 1'b0);
        drain(0);
        for (int k = 0; k < 3; k++) tick();

        // Carry chain, overflow and subtract corners, back to back
        issue(0, 64'hFFFF_FFFF, 64'h0000_0000, 1'b1, 1'b0);
        issue(0, 64'h7FFF_FFFF, 64'h0000_0001, 1'b0, 1'b0);
        issue(0, 64'h0000_0003, 64'h0000_0005, 1'b0, 1'b1);
        issue(0, 64'h8000_0000, 64'h0000_0001, 1'b0, 1'b1);
        drain(0);

        // Random stream with a stall window
        run_stream(0, 16, 6, 9);

        // Reset with three operations in flight: none may emerge
        issue(0, 64'h1111_1111, 64'h2222_2222, 1'b0, 1'b0);
        issue(0, 64'h3333_3333, 64'h0000_0001, 1'b1, 1'b1);
        issue(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("rst_drop_valid0", o_ov[0], 0);
        end
        issue(0, 64'h0000_00FF, 64'h0000_0001, 1'b0, 1'b0);
        drain(0);

        // Other configurations
        issue(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
        issue(1, 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1);
        drain(1);
        run_stream(1, 16, 10, 13);
        issue(2, 64'h7FFF, 64'h0001, 1'b0, 1'b0);
        issue(2, 64'h0003, 64'h0005, 1'b0, 1'b1);
        drain(2);
        run_stream(2, 16, 6, 9);

        for (int k = 0; k < 5; k++) tick();
        for (int i = 0; i < 3; i++) chk($sformatf("final_empty%0d", i), qsize(i), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipelined_cla_addsub.md
Name: pipelined_cla_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor.
- Next generation of the team's 32-bit clocked CLA adder: generic width, configurable pipeline depth, add/sub mode, status flags and valid/ready flow control.
- Sits in the integer execution datapath between the operand-fetch stage and the writeback stage.
- Sustains one operation per cycle when not back-pressured.

Parameters:
- WIDTH, 32, operand and result width in bits.
- STAGES, 4, number of pipeline stages. WIDTH must be divisible by STAGES. Each stage adds one WIDTH/STAGES-bit slice.
- GROUP, 4, carry-lookahead group size inside a slice. Must divide WIDTH/STAGES. Slice uses 2-level lookahead over its groups.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operands present this cycle
- in_ready  out  1  block can accept an operation this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  0 = a+b+cin; 1 = a-b-cin
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry-out (add) / NOT borrow-out (sub)
- ovf  out  1  signed two's-complement overflow
- zero  out  1  sum == 0

Behaviour:
- Reset (rst_n low at a rising edge): all stage valid bits clear, then out_valid=0, sum=0, cout=0, ovf=0, zero=0. Operands held in the pipeline are discarded; a reset mid-operation drops all in-flight operations. in_ready=1 from the first cycle after reset.
- Operand preparation at accept: b_eff = sub ? ~b : b; c0 = sub ? ~cin : cin. Stage 0 captures a, b_eff, c0 and the sign bits a[WIDTH-1] and b_eff[WIDTH-1].
- Stage k (k = 0..STAGES-1):
  - Adds slice k (bits [(k+1)*W/S-1 : k*W/S]) with its CLA, using the carry registered from stage k-1 (c0 for k=0).
  - Registers the partial sum, the slice carry-out and the remaining unprocessed operand slices.
  - Earlier result slices shift along with the operation; no combinational carry path crosses a stage register.
- Latency: exactly STAGES cycles from accept (in_valid & in_ready at edge N) to out_valid=1 after edge N+STAGES-1, with no stalls. Throughput: 1 per cycle.
- Final flags, computed in the last stage and registered with sum:
  - cout = carry out of bit WIDTH-1.
  - ovf = (a_msb == b_eff_msb) & (sum_msb != a_msb).
  - zero = ~|sum.
- Flow control is a global stall:
  - advance = ~out_valid | out_ready.
  - in_ready = advance (combinational).
  - When advance=0, every stage register, including the output, holds. Outputs stay stable while out_valid=1 and out_ready=0.
  - Bubbles (in_valid=0 accepted while advancing) propagate as invalid entries. Output registers are updated only when a valid entry arrives; sum/flags hold their last value while out_valid=0.
- Simultaneous accept and emit: allowed in the same cycle; no lost or duplicated operations.
- Arithmetic is modulo 2^WIDTH; there is no saturation.
- Parameter-check failure (WIDTH % STAGES or slice % GROUP nonzero): elaboration-time error.

Test Plan:
- Reset, then a=0x0000_0005, b=0x0000_0003, cin=0, sub=0, single pulse → exactly 4 cycles later out_valid=1 for one cycle with out_ready=1; sum=0x0000_0008, cout=0, ovf=0, zero=0.
- Full carry chain: a=0xFFFF_FFFF, b=0x0000_0000, cin=1, sub=0 → sum=0x0000_0000, cout=1, zero=1, ovf=0. Then a=0x7FFF_FFFF, b=1, cin=0 → sum=0x8000_0000, ovf=1, cout=0.
- Subtract: a=0x0000_0003, b=0x0000_0005, sub=1, cin=0 → sum=0xFFFF_FFFE, cout=0 (borrow). Then a=0x8000_0000, b=1, sub=1 → sum=0x7FFF_FFFF, ovf=1, cout=1.
- Back-to-back stream of 16 random operations with in_valid=1 throughout; out_ready=0 for cycles 6-9 → in_ready=0 during the stall, outputs held stable, all 16 results emerge in order, each matching the reference model (a±b±cin mod 2^32 plus flags).
- Reset asserted 2 cycles after accepting 3 operations → out_valid stays 0 and none of the 3 results ever appear; a new operation issued after reset completes with 4-cycle latency.
- Re-run the random stream with WIDTH=64, STAGES=8, GROUP=4 and with WIDTH=16, STAGES=1 → 8-cycle and 1-cycle latency respectively; all results match the model.
